// File: rtl/simon_entry_ctrl.sv
// Key-entry sequencer for the Simon pattern display: matches key events against
// an 8-step pattern, tracks failures, and times the error hold, lockout and idle abandon.
module simon_entry_ctrl #(
    parameter logic [23:0] PATTERN        = 24'h8F2E29,
    parameter int          MAX_FAIL       = 3,
    parameter int          HOLD_CYCLES    = 4,
    parameter int          LOCK_CYCLES    = 16,
    parameter int          TIMEOUT_CYCLES = 32,
    parameter int          TW             = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [2:0] key_code,
    input  logic       clear,
    output logic       correct,
    output logic       err,
    output logic       locked,
    output logic [3:0] progress,
    output logic [3:0] fail_cnt,
    output logic       show_pattern
);

    typedef enum logic [1:0] {
        ST_ENTRY     = 2'd0,
        ST_FAIL_HOLD = 2'd1,
        ST_SUCCESS   = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    localparam logic [TW-1:0] HOLD_LAST    = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST    = TW'(LOCK_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    FAIL_LIMIT   = 4'(MAX_FAIL);

    state_t        state_q, state_d;
    logic [3:0]    progress_q, progress_d;
    logic [3:0]    fail_cnt_q, fail_cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          correct_q, err_q, locked_q, show_q;

    logic [2:0] step_tab [8];
    logic [2:0] exp_step;
    logic [3:0] fail_inc;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_step
            assign step_tab[gi] = PATTERN[3*gi +: 3];
        end
    endgenerate

    // progress never exceeds 7 while in ENTRY, so the low three bits select the step
    assign exp_step = step_tab[progress_q[2:0]];
    assign fail_inc = (fail_cnt_q >= FAIL_LIMIT) ? fail_cnt_q : fail_cnt_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q;
        case (state_q)
            ST_ENTRY: begin
                if (key_valid) begin
                    timer_d = '0;
                    if (key_code == exp_step) begin
                        progress_d = progress_q + 4'd1;
                        if (progress_q == 4'd7) begin
                            fail_cnt_d = '0;
                            state_d    = ST_SUCCESS;
                        end
                    end else begin
                        progress_d = '0;
                        fail_cnt_d = fail_inc;
                        state_d    = (fail_inc == FAIL_LIMIT) ? ST_LOCKED : ST_FAIL_HOLD;
                    end
                end else if (progress_q != 4'd0) begin
                    // a key in the firing cycle takes the branch above, discarding the timeout
                    if (timer_q == TIMEOUT_LAST) begin
                        progress_d = '0;
                        timer_d    = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            ST_FAIL_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    state_d    = ST_ENTRY;
                    progress_d = '0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                if (timer_q == LOCK_LAST) begin
                    state_d    = ST_ENTRY;
                    fail_cnt_d = '0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_SUCCESS: begin
                if (clear) begin
                    state_d    = ST_ENTRY;
                    progress_d = '0;
                    timer_d    = '0;
                end
            end
            default: begin
                state_d    = ST_ENTRY;
                progress_d = '0;
                timer_d    = '0;
            end
        endcase
    end

    // status flags are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ENTRY;
            progress_q <= '0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
            correct_q  <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
            show_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            correct_q  <= (state_d == ST_SUCCESS);
            err_q      <= (state_d == ST_FAIL_HOLD);
            locked_q   <= (state_d == ST_LOCKED);
            show_q     <= (state_d == ST_ENTRY) && (progress_d == 4'd0);
        end
    end

    assign correct      = correct_q;
    assign err          = err_q;
    assign locked       = locked_q;
    assign progress     = progress_q;
    assign fail_cnt     = fail_cnt_q;
    assign show_pattern = show_q;

endmodule

// File: tb/tb_simon_entry_ctrl.sv
// Bench for simon_entry_ctrl: vector table, directed multi-cycle sequences,
// and randomized traffic checked against a countdown-based reference model.
module tb_simon_entry_ctrl;

    localparam logic [23:0] PAT      = 24'h8F2E29;
    localparam int          MAXF     = 3;
    localparam int          HOLD     = 4;
    localparam int          LOCK     = 16;
    localparam int          TIMEOUT  = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [2:0] key_code = 3'd0;
    logic       clear = 1'b0;
    logic       correct, err, locked, show_pattern;
    logic [3:0] progress, fail_cnt;

    int checks = 0;
    int errors = 0;

    simon_entry_ctrl #(
        .PATTERN(PAT), .MAX_FAIL(MAXF), .HOLD_CYCLES(HOLD),
        .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TIMEOUT), .TW(24)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .clear(clear), .correct(correct), .err(err), .locked(locked),
        .progress(progress), .fail_cnt(fail_cnt), .show_pattern(show_pattern)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 entry, 1 error hold, 2 success, 3 lockout
    int m_mode, m_prog, m_fail, m_rem, m_idle;

    task automatic model_reset();
        m_mode = 0; m_prog = 0; m_fail = 0; m_rem = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit kv, input bit [2:0] kc, input bit clr);
        int want;
        case (m_mode)
            0: begin
                if (kv) begin
                    want = int'((PAT >> (3 * m_prog)) & 24'h7);
                    m_idle = 0;
                    if (int'(kc) == want) begin
                        m_prog++;
                        if (m_prog == 8) begin m_mode = 2; m_fail = 0; end
                    end else begin
                        m_prog = 0;
                        m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
                        if (m_fail == MAXF) begin m_mode = 3; m_rem = LOCK; end
                        else begin m_mode = 1; m_rem = HOLD; end
                    end
                end else if (m_prog > 0) begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin m_prog = 0; m_idle = 0; end
                end
            end
            1: begin
                m_rem--;
                if (m_rem == 0) m_mode = 0;
            end
            3: begin
                m_rem--;
                if (m_rem == 0) begin m_mode = 0; m_fail = 0; end
            end
            default: begin
                if (clr) begin m_mode = 0; m_prog = 0; end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    task automatic check_model();
        chk("model_correct", {7'd0, correct}, {7'd0, m_mode == 2});
        chk("model_err", {7'd0, err}, {7'd0, m_mode == 1});
        chk("model_locked", {7'd0, locked}, {7'd0, m_mode == 3});
        chk("model_progress", {4'd0, progress}, 8'(m_prog));
        chk("model_fail_cnt", {4'd0, fail_cnt}, 8'(m_fail));
        chk("model_show", {7'd0, show_pattern}, {7'd0, (m_mode == 0) && (m_prog == 0)});
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic cycle(input bit kv, input bit [2:0] kc, input bit clr);
        key_valid = kv; key_code = kc; clear = clr;
        @(posedge clk);
        model_step(kv, kc, clr);
        @(negedge clk);
        key_valid = 1'b0; key_code = 3'd0; clear = 1'b0;
        check_model();
    endtask

    task automatic wait_err_clear(input string name);
        int n = 0;
        while (err === 1'b1 && n < 10) begin cycle(0, 0, 0); n++; end
        chk(name, {7'd0, err}, 8'd0);
    endtask

    task automatic do_lockout();
        cycle(1, 3'd0, 0); wait_err_clear("lk_err1");
        cycle(1, 3'd0, 0); wait_err_clear("lk_err2");
        cycle(1, 3'd0, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_correct"}, {7'd0, correct}, 8'd0);
        chk({name, "_err"}, {7'd0, err}, 8'd0);
        chk({name, "_locked"}, {7'd0, locked}, 8'd0);
        chk({name, "_progress"}, {4'd0, progress}, 8'd0);
        chk({name, "_fail_cnt"}, {4'd0, fail_cnt}, 8'd0);
        chk({name, "_show"}, {7'd0, show_pattern}, 8'd1);
    endtask

    // Drops rst_n between clock edges and checks outputs before any edge occurs.
    task automatic async_reset(input string name);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(name);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        $display("async reset %s applied", name);
    endtask

    typedef struct {
        bit       kv;
        bit [2:0] kc;
        bit       clr;
        bit [3:0] prog;
        bit       corr;
        bit       er;
        bit       show;
    } vec_t;

    vec_t vecs[$];
    int   pat_seq[8] = '{1, 5, 0, 7, 2, 6, 3, 4};

    initial begin
        int cnt;
        vec_t v;

        for (int i = 0; i < 8; i++) begin
            v = '{1'b1, 3'(pat_seq[i]), 1'b0, 4'(i + 1), i == 7, 1'b0, 1'b0};
            vecs.push_back(v);
            v.kv = 1'b0; v.kc = 3'd0;
            vecs.push_back(v);
            vecs.push_back(v);
        end
        vecs.push_back('{1'b1, 3'd1, 1'b1, 4'd8, 1'b1, 1'b0, 1'b0});  // clear low: key ignored
        vecs.push_back('{1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'd2, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0});  // wrong first key
        vecs.push_back('{1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd5, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0});

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // The 8-step pattern, then the clear/SUCCESS handling and a first miss.
        // Row 25 keeps clear low so SUCCESS is held; row 26 clears it.
        vecs[24].clr = 1'b0;
        foreach (vecs[i]) begin
            cycle(vecs[i].kv, vecs[i].kc, vecs[i].clr);
            chk("vec_progress", {4'd0, progress}, {4'd0, vecs[i].prog});
            chk("vec_correct", {7'd0, correct}, {7'd0, vecs[i].corr});
            chk("vec_err", {7'd0, err}, {7'd0, vecs[i].er});
            chk("vec_show", {7'd0, show_pattern}, {7'd0, vecs[i].show});
            $display("vec %0d kv=%0d kc=%0d clr=%0d -> progress=%0d correct=%0d",
                     i, vecs[i].kv, vecs[i].kc, vecs[i].clr, progress, correct);
        end

        // Wrong third key: err for exactly HOLD cycles, key during err ignored.
        cycle(1, 3'd3, 0);
        cnt = 0;
        if (err === 1'b1) cnt++;
        cycle(1, 3'd1, 0);
        if (err === 1'b1) cnt++;
        for (int i = 0; i < 10 && err === 1'b1; i++) begin
            cycle(0, 0, 0);
            if (err === 1'b1) cnt++;
        end
        chk("hold_err_cycles", 8'(cnt), 8'(HOLD));
        chk("hold_progress", {4'd0, progress}, 8'd0);
        chk("hold_fail_cnt", {4'd0, fail_cnt}, 8'd2);
        $display("hold sequence: err cycles=%0d fail_cnt=%0d", cnt, fail_cnt);

        // Clear failures with a full success, then test the idle timeout.
        for (int i = 0; i < 8; i++) cycle(1, 3'(pat_seq[i]), 0);
        chk("succ_fail_cnt", {4'd0, fail_cnt}, 8'd0);
        cycle(0, 0, 1);
        cycle(1, 3'd1, 0);
        cycle(1, 3'd5, 0);
        repeat (TIMEOUT - 1) cycle(0, 0, 0);
        chk("to_before", {4'd0, progress}, 8'd2);
        cycle(0, 0, 0);
        chk("to_after", {4'd0, progress}, 8'd0);
        chk("to_err", {7'd0, err}, 8'd0);
        chk("to_fail_cnt", {4'd0, fail_cnt}, 8'd0);
        $display("timeout sequence: progress=%0d", progress);
        cycle(1, 3'd1, 0);
        cycle(1, 3'd5, 0);
        repeat (TIMEOUT - 1) cycle(0, 0, 0);
        cycle(1, 3'd0, 0);
        chk("to_race_progress", {4'd0, progress}, 8'd3);
        $display("timeout race: progress=%0d", progress);
        for (int i = 3; i < 8; i++) cycle(1, 3'(pat_seq[i]), 0);
        cycle(1, 3'd1, 1);
        chk("succ_clear_key_progress", {4'd0, progress}, 8'd0);
        chk("succ_clear_key_correct", {7'd0, correct}, 8'd0);

        // Lockout: three misses, keys and clear ignored for LOCK cycles.
        do_lockout();
        chk("lock_fail_cnt", {4'd0, fail_cnt}, 8'(MAXF));
        cnt = 0;
        if (locked === 1'b1) cnt++;
        for (int i = 0; i < 40 && locked === 1'b1; i++) begin
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (locked === 1'b1) cnt++;
        end
        chk("lock_cycles", 8'(cnt), 8'(LOCK));
        chk("lock_after_fail_cnt", {4'd0, fail_cnt}, 8'd0);
        chk("lock_after_show", {7'd0, show_pattern}, 8'd1);
        $display("lockout sequence: locked cycles=%0d", cnt);

        // Asynchronous reset mid-lockout and mid-entry.
        do_lockout();
        repeat (3) cycle(0, 0, 0);
        chk("pre_reset_locked", {7'd0, locked}, 8'd1);
        async_reset("rst_lock");
        for (int i = 0; i < 5; i++) cycle(1, 3'(pat_seq[i]), 0);
        chk("pre_reset_progress", {4'd0, progress}, 8'd5);
        async_reset("rst_prog");

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 25; seg++) begin
            for (int i = 0; i < 100; i++) begin
                bit       kv;
                bit [2:0] kc;
                kv = (seg % 4 == 3) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
                kc = ($urandom_range(0, 3) != 0) ? 3'((PAT >> (3 * m_prog)) & 24'h7)
                                                  : 3'($urandom_range(0, 7));
                cycle(kv, kc, $urandom_range(0, 5) == 0);
            end
            $display("random segment %0d done, progress=%0d fail_cnt=%0d", seg, progress, fail_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
